// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write port arbiter with multi-cycle result FIFO and hazard detect
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                            i_clk,
    input  logic                            i_arstn,
    input  logic                            i_wb_we,
    input  logic [REG_ADDR_W-1:0]           i_wb_addr,
    input  logic [DATA_WIDTH-1:0]           i_wb_data,
    input  logic                            i_mc_valid,
    input  logic [REG_ADDR_W-1:0]           i_mc_addr,
    input  logic [DATA_WIDTH-1:0]           i_mc_data,
    output logic                            o_mc_ready,
    input  logic [REG_ADDR_W-1:0]           i_rs1_addr,
    input  logic [REG_ADDR_W-1:0]           i_rs2_addr,
    input  logic [REG_ADDR_W-1:0]           i_rd_addr,
    output logic                            o_reg_we,
    output logic [REG_ADDR_W-1:0]           o_rd_addr,
    output logic [DATA_WIDTH-1:0]           o_rd_write_data,
    output logic                            o_hazard,
    output logic                            o_wb_hold,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX) + 1;

    logic [REG_ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [ST_W-1:0]       starve_cnt;
    logic [ST_W-1:0]       starve_next;
    logic                  hold_q;

    logic                  wb_act;
    logic                  fifo_nonempty;
    logic                  pop;
    logic                  push;
    logic [PTR_W-1:0]      slot_off [FIFO_DEPTH];
    logic                  hazard;

    assign wb_act        = i_wb_we && (i_wb_addr != '0);
    assign fifo_nonempty = (count != '0);
    assign pop           = i_arstn && !wb_act && fifo_nonempty;
    // Ready uses the pre-pop count, so a full FIFO never pushes even when popping.
    assign o_mc_ready    = i_arstn && (count < CNT_W'(FIFO_DEPTH));
    // x0 results finish the handshake but are discarded.
    assign push          = i_mc_valid && o_mc_ready && (i_mc_addr != '0);
    assign o_fifo_count  = count;
    assign o_wb_hold     = hold_q;
    assign o_hazard      = hazard && i_arstn;

    // Write-port mux: writeback always wins, otherwise drain the FIFO head.
    always_comb begin
        o_reg_we        = 1'b0;
        o_rd_addr       = '0;
        o_rd_write_data = '0;
        if (i_arstn) begin
            if (wb_act) begin
                o_reg_we        = 1'b1;
                o_rd_addr       = i_wb_addr;
                o_rd_write_data = i_wb_data;
            end else if (fifo_nonempty) begin
                o_reg_we        = 1'b1;
                o_rd_addr       = q_addr[rd_ptr];
                o_rd_write_data = q_data[rd_ptr];
            end
        end
    end

    // Distance of each slot from the head, wrapped to the pointer width.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_off[i] = PTR_W'(i) - rd_ptr;
        end
    end

    // Hazard when any occupied slot targets a nonzero decode operand; the head being popped still counts.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(slot_off[i]) < count) && (q_addr[i] != '0)) begin
                if (((i_rs1_addr != '0) && (q_addr[i] == i_rs1_addr)) ||
                    ((i_rs2_addr != '0) && (q_addr[i] == i_rs2_addr)) ||
                    ((i_rd_addr  != '0) && (q_addr[i] == i_rd_addr))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Count consecutive lost arbitrations of the head, saturating so it never wraps.
    always_comb begin
        starve_next = starve_cnt;
        if (!fifo_nonempty || pop) begin
            starve_next = '0;
        end else if (starve_cnt != ST_W'(STARVE_MAX)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_addr[wr_ptr] <= i_mc_addr;
            q_data[wr_ptr] <= i_mc_data;
        end
    end

    // Pointers, occupancy, starvation counter and the registered hold request.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            starve_cnt <= starve_next;
            hold_q     <= (starve_next >= ST_W'(STARVE_MAX - 1));
        end
    end

    // Occupancy can never overflow or underflow given the ready/pop qualifiers.
    always_ff @(posedge i_clk) begin
        if (i_arstn) begin
            assert (!(push && !pop && (count == CNT_W'(FIFO_DEPTH))));
            assert (!(pop && (count == '0)));
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - randomized self-checking bench for rf_write_arbiter against a queue model
module tb_rf_write_arbiter;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic          clk;
    logic          arstn;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          mc_valid;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          mc_ready;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [AW-1:0] rd_addr;
    logic          reg_we;
    logic [AW-1:0] rd_waddr;
    logic [DW-1:0] rd_wdata;
    logic          hazard;
    logic          wb_hold;
    logic [2:0]    fifo_count;

    int tests  = 0;
    int failed = 0;

    // Reference model: pending multi-cycle writes in acceptance order.
    logic [AW-1:0] m_addr [$];
    logic [DW-1:0] m_data [$];
    int            losses   = 0;
    logic          exp_hold = 1'b0;

    rf_write_arbiter #(
        .DATA_WIDTH(DW), .REG_ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .i_clk(clk), .i_arstn(arstn),
        .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_mc_valid(mc_valid), .i_mc_addr(mc_addr), .i_mc_data(mc_data), .o_mc_ready(mc_ready),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
        .o_reg_we(reg_we), .o_rd_addr(rd_waddr), .o_rd_write_data(rd_wdata),
        .o_hazard(hazard), .o_wb_hold(wb_hold), .o_fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check settled outputs, then advance the model.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] rd);
        logic          act;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_ready;
        logic          e_haz;
        logic          was_empty;
        logic          did_pop;
        @(negedge clk);
        wb_we = we; wb_addr = wa; wb_data = wd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
        #1;
        act    = we && (wa != 0);
        e_we   = 1'b0;
        e_addr = '0;
        e_data = '0;
        if (act) begin
            e_we = 1'b1; e_addr = wa; e_data = wd;
        end else if (m_addr.size() > 0) begin
            e_we = 1'b1; e_addr = m_addr[0]; e_data = m_data[0];
        end
        e_ready = (m_addr.size() < DEPTH);
        e_haz   = 1'b0;
        foreach (m_addr[k]) begin
            if ((r1 != 0 && m_addr[k] == r1) || (r2 != 0 && m_addr[k] == r2) ||
                (rd != 0 && m_addr[k] == rd))
                e_haz = 1'b1;
        end
        check("reg_we",   64'(reg_we),     64'(e_we));
        check("rd_addr",  64'(rd_waddr),   64'(e_addr));
        check("rd_data",  rd_wdata,        e_data);
        check("mc_ready", 64'(mc_ready),   64'(e_ready));
        check("hazard",   64'(hazard),     64'(e_haz));
        check("wb_hold",  64'(wb_hold),    64'(exp_hold));
        check("count",    64'(fifo_count), 64'(m_addr.size()));
        was_empty = (m_addr.size() == 0);
        did_pop   = !act && !was_empty;
        if (did_pop) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
        end
        if (mv && e_ready && ma != 0) begin
            m_addr.push_back(ma);
            m_data.push_back(md);
        end
        losses   = (was_empty || did_pop) ? 0 : losses + 1;
        exp_hold = (losses >= SMAX - 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic busy(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 5'd3, 64'h3333 + 64'(i), 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        arstn = 1'b0; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'h55;
        mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 64'h66;
        rs1_addr = 5'd6; rs2_addr = 5'd0; rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_reg_we",   64'(reg_we),     64'd0);
        check("rst_mc_ready", 64'(mc_ready),   64'd0);
        check("rst_count",    64'(fifo_count), 64'd0);
        check("rst_hazard",   64'(hazard),     64'd0);
        check("rst_wb_hold",  64'(wb_hold),    64'd0);
        mc_valid = 1'b0; wb_we = 1'b0;
        arstn = 1'b1;
        #1;
        check("post_rst_ready", 64'(mc_ready), 64'd1);

        // Idle drain: result appears on the port one cycle after acceptance.
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAA, 5'd0, 5'd0, 5'd0);
        idle(2);

        // Writeback priority, then in-order drain.
        step(1'b1, 5'd3, 64'h31, 1'b1, 5'd10, 64'h1010, 5'd0, 5'd0, 5'd0);
        step(1'b1, 5'd3, 64'h32, 1'b1, 5'd11, 64'h1111, 5'd0, 5'd0, 5'd0);
        busy(3);
        idle(3);

        // Fill to capacity, hold a fifth result until a pop frees space.
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd3, 64'h40, 1'b1, 5'(12 + i), 64'hC00 + 64'(i), 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 2; i++)
            step(1'b1, 5'd3, 64'h41, 1'b1, 5'd20, 64'h2020, 5'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'h2020, 5'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'h2020, 5'd0, 5'd0, 5'd0);
        idle(6);

        // Hazard on a queued register; x0 results are never queued or written.
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 5'd0, 5'd0, 5'd0);
        step(1'b1, 5'd3, 64'h50, 1'b0, 5'd0, 64'd0, 5'd0, 5'd9, 5'd0);
        step(1'b1, 5'd3, 64'h51, 1'b1, 5'd0, 64'hDEAD, 5'd0, 5'd0, 5'd0);
        step(1'b1, 5'd3, 64'h52, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 5'd9);
        idle(2);

        // Starvation: one queued entry loses to writeback until hold asserts.
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h5555, 5'd0, 5'd0, 5'd0);
        busy(10);
        idle(3);

        // Randomized traffic with bursty writeback and small address space for frequent hazards.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                logic          we;
                logic          mv;
                int            wb_pct;
                wb_pct = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 95 : 50;
                we = ($urandom_range(0, 99) < wb_pct);
                mv = ($urandom_range(0, 99) < 50);
                step(we, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                     mv, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
